// File: rtl/checkout_controller.sv
`default_nettype none
// ============================================================================
// Module   : checkout_controller
// Purpose  : Transaction sequencer for the bar-code cash register. Latches
//            the scanned price, accumulates inserted coins, chooses refund or
//            change on confirm/cancel/timeout and drives the state, money and
//            price buses into the change-calculation datapath.
// Ports    : clk, reset (sync, active-high)
//            scanValid/scanFound/scanPrice  - scanner result strobe
//            coinValid/coinValue            - coin acceptor strobe
//            confirm, cancel                - customer buttons
//            mainState  [2:0] - 0 IDLE, 1 WAIT_MONEY, 2 REFUND, 3 CHANGE
//            inputMoney [4:0] - accumulated coin total
//            valueToPay [4:0] - latched price
//            dispense, coinReject, scanError - one-cycle pulses
// Revision : 1.0 - initial release
// ============================================================================
module checkout_controller #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HOLD_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scanValid,
    input  logic       scanFound,
    input  logic [4:0] scanPrice,
    input  logic       coinValid,
    input  logic [4:0] coinValue,
    input  logic       confirm,
    input  logic       cancel,
    output logic [2:0] mainState,
    output logic [4:0] inputMoney,
    output logic [4:0] valueToPay,
    output logic       dispense,
    output logic       coinReject,
    output logic       scanError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_REFUND = 3'd2;
    localparam logic [2:0] c_ST_CHANGE = 3'd3;

    // The timer holds (cycles since last activity - 1); the timeout fires
    // when its incremented value reaches TIMEOUT_CYCLES-1, which puts REFUND
    // exactly TIMEOUT_CYCLES cycles after the last accepted coin or scan.
    localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] c_HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    logic [2:0]    r_state;
    logic [4:0]    r_inputMoney;
    logic [4:0]    r_valueToPay;
    logic [TW-1:0] r_timer;
    logic [HW-1:0] r_hold;
    logic          r_dispense;
    logic          r_coinReject;
    logic          r_scanError;

    logic [2:0]    w_stateNext;
    logic [4:0]    w_inputMoneyNext;
    logic [4:0]    w_valueToPayNext;
    logic [TW-1:0] w_timerNext;
    logic [HW-1:0] w_holdNext;
    logic          w_dispenseNext;
    logic          w_coinRejectNext;
    logic          w_scanErrorNext;

    logic [5:0]    w_coinSum;
    logic [TW-1:0] w_timerInc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_inputMoney <= '0;
            r_valueToPay <= '0;
            r_timer      <= '0;
            r_hold       <= '0;
            r_dispense   <= 1'b0;
            r_coinReject <= 1'b0;
            r_scanError  <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_inputMoney <= w_inputMoneyNext;
            r_valueToPay <= w_valueToPayNext;
            r_timer      <= w_timerNext;
            r_hold       <= w_holdNext;
            r_dispense   <= w_dispenseNext;
            r_coinReject <= w_coinRejectNext;
            r_scanError  <= w_scanErrorNext;
        end
    end

    always_comb begin
        w_stateNext      = r_state;
        w_inputMoneyNext = r_inputMoney;
        w_valueToPayNext = r_valueToPay;
        w_timerNext      = r_timer;
        w_holdNext       = r_hold;
        w_dispenseNext   = 1'b0;
        w_coinRejectNext = 1'b0;
        w_scanErrorNext  = 1'b0;

        // Bit 5 of the widened sum flags a total that no longer fits in 5 bits.
        w_coinSum  = {1'b0, r_inputMoney} + {1'b0, coinValue};
        w_timerInc = r_timer + 1'b1;

        case (r_state)
            c_ST_IDLE: begin
                w_coinRejectNext = coinValid;
                if (scanValid) begin
                    if (scanFound) begin
                        w_stateNext      = c_ST_WAIT;
                        w_valueToPayNext = scanPrice;
                        w_inputMoneyNext = '0;
                        w_timerNext      = '0;
                    end else begin
                        w_scanErrorNext = 1'b1;
                    end
                end
            end

            c_ST_WAIT: begin
                if (cancel) begin
                    w_stateNext      = c_ST_REFUND;
                    w_holdNext       = '0;
                    w_coinRejectNext = coinValid;
                end else if (confirm) begin
                    w_holdNext       = '0;
                    w_coinRejectNext = coinValid;
                    if (r_inputMoney >= r_valueToPay) begin
                        w_stateNext    = c_ST_CHANGE;
                        w_dispenseNext = 1'b1;
                    end else begin
                        w_stateNext = c_ST_REFUND;
                    end
                end else if (w_timerInc == c_TIMER_LAST) begin
                    // A coin arriving on the timeout cycle is too late to count.
                    w_stateNext      = c_ST_REFUND;
                    w_holdNext       = '0;
                    w_coinRejectNext = coinValid;
                end else if (coinValid && !w_coinSum[5]) begin
                    w_inputMoneyNext = w_coinSum[4:0];
                    w_timerNext      = '0;
                end else begin
                    w_coinRejectNext = coinValid;
                    w_timerNext      = w_timerInc;
                end
            end

            c_ST_REFUND, c_ST_CHANGE: begin
                // Money and price stay frozen so the datapath sees stable
                // operands for the whole hold window.
                w_coinRejectNext = coinValid;
                if (r_hold == c_HOLD_LAST) begin
                    w_stateNext      = c_ST_IDLE;
                    w_inputMoneyNext = '0;
                    w_valueToPayNext = '0;
                end else begin
                    w_holdNext = r_hold + 1'b1;
                end
            end

            default: begin
                // Unreachable encodings recover to a clean IDLE.
                w_stateNext      = c_ST_IDLE;
                w_inputMoneyNext = '0;
                w_valueToPayNext = '0;
                w_timerNext      = '0;
                w_holdNext       = '0;
            end
        endcase
    end

    assign mainState  = r_state;
    assign inputMoney = r_inputMoney;
    assign valueToPay = r_valueToPay;
    assign dispense   = r_dispense;
    assign coinReject = r_coinReject;
    assign scanError  = r_scanError;

endmodule
`default_nettype wire

// File: tb/tb_checkout_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_checkout_controller
// Purpose  : Self-checking bench for checkout_controller: directed vector
//            table, hand-written timeout sequences and random stimulus
//            against a cycle-numbered behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_checkout_controller;

    localparam int c_TIMEOUT = 10;
    localparam int c_HOLD    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       scanValid;
    logic       scanFound;
    logic [4:0] scanPrice;
    logic       coinValid;
    logic [4:0] coinValue;
    logic       confirm;
    logic       cancel;
    logic [2:0] mainState;
    logic [4:0] inputMoney;
    logic [4:0] valueToPay;
    logic       dispense;
    logic       coinReject;
    logic       scanError;

    checkout_controller #(
        .TIMEOUT_CYCLES(c_TIMEOUT),
        .HOLD_CYCLES   (c_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scanValid (scanValid),
        .scanFound (scanFound),
        .scanPrice (scanPrice),
        .coinValid (coinValid),
        .coinValue (coinValue),
        .confirm   (confirm),
        .cancel    (cancel),
        .mainState (mainState),
        .inputMoney(inputMoney),
        .valueToPay(valueToPay),
        .dispense  (dispense),
        .coinReject(coinReject),
        .scanError (scanError)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: state plus cycle numbers of the last activity and of
    // the start of the hold window.
    int m_state = 0, m_money = 0, m_price = 0, m_lastEvent = 0, m_holdStart = 0;
    int m_disp = 0, m_rej = 0, m_err = 0;

    typedef struct {
        logic       rs, sv, sf;
        logic [4:0] sp;
        logic       cv;
        logic [4:0] cval;
        logic       cf, cn;
        logic [2:0] est;
        logic [4:0] eim, evtp;
        logic       ed, er, ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rs, logic sv, logic sf, int sp, logic cv, int cval,
                                logic cf, logic cn, int est, int eim, int evtp,
                                logic ed, logic er, logic ee);
        vec_t v;
        v.rs = rs; v.sv = sv; v.sf = sf; v.sp = 5'(sp); v.cv = cv; v.cval = 5'(cval);
        v.cf = cf; v.cn = cn; v.est = 3'(est); v.eim = 5'(eim); v.evtp = 5'(evtp);
        v.ed = ed; v.er = er; v.ee = ee;
        return v;
    endfunction

    function automatic logic [15:0] dutVec();
        return {mainState, inputMoney, valueToPay, dispense, coinReject, scanError};
    endfunction

    function automatic logic [15:0] modelVec();
        return {3'(m_state), 5'(m_money), 5'(m_price), m_disp[0], m_rej[0], m_err[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic modelStep();
        m_disp = 0; m_rej = 0; m_err = 0;
        if (reset) begin
            m_state = 0; m_money = 0; m_price = 0;
            return;
        end
        case (m_state)
            0: begin
                m_rej = int'(coinValid);
                if (scanValid) begin
                    if (scanFound) begin
                        m_state = 1; m_price = int'(scanPrice); m_money = 0; m_lastEvent = cyc;
                    end else begin
                        m_err = 1;
                    end
                end
            end
            1: begin
                if (cancel || confirm) begin
                    m_rej = int'(coinValid);
                    m_holdStart = cyc + 1;
                    if (!cancel && m_money >= m_price) begin
                        m_state = 3; m_disp = 1;
                    end else begin
                        m_state = 2;
                    end
                end else if (cyc - m_lastEvent == c_TIMEOUT - 1) begin
                    m_rej = int'(coinValid);
                    m_holdStart = cyc + 1;
                    m_state = 2;
                end else if (coinValid) begin
                    if (m_money + int'(coinValue) <= 31) begin
                        m_money = m_money + int'(coinValue);
                        m_lastEvent = cyc;
                    end else begin
                        m_rej = 1;
                    end
                end
            end
            default: begin
                m_rej = int'(coinValid);
                if (cyc + 1 - m_holdStart == c_HOLD) begin
                    m_state = 0; m_money = 0; m_price = 0;
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs, advance the model, clock, and compare.
    task automatic step(input logic rs, input logic sv, input logic sf, input logic [4:0] sp,
                        input logic cv, input logic [4:0] cval, input logic cf, input logic cn);
        reset = rs; scanValid = sv; scanFound = sf; scanPrice = sp;
        coinValid = cv; coinValue = cval; confirm = cf; cancel = cn;
        modelStep();
        @(posedge clk);
        #1;
        check("model", 32'(dutVec()), 32'(modelVec()));
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; scanValid = 1'b0; scanFound = 1'b0; scanPrice = '0;
        coinValid = 1'b0; coinValue = '0; confirm = 1'b0; cancel = 1'b0;

        //            rs sv sf sp cv cval cf cn | st im vtp d  r  e
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,  7, 0,  0, 0, 0, 1,  0,  7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  5, 0, 0, 1,  5,  7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  2, 0, 0, 1,  7,  7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 1, 0, 3,  7,  7, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 3,  7,  7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 3,  7,  7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 3,  7,  7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 12, 0,  0, 0, 0, 0,  0,  0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 1,  3, 0, 0, 0,  0,  0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 20, 0,  0, 0, 0, 1,  0, 20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1, 10, 0, 0, 1, 10, 20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  5, 0, 0, 1, 15, 20, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,  9, 0,  0, 0, 0, 1, 15, 20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  1, 1, 0, 2, 15, 20, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  4, 0, 0, 2, 15, 20, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 2, 15, 20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 2, 15, 20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,  3, 0,  0, 0, 0, 1,  0,  3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  5, 0, 0, 1,  5,  3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 1, 1, 2,  5,  3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 2,  5,  3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 2,  5,  3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 2,  5,  3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,  1, 0,  0, 0, 0, 1,  0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1, 20, 0, 0, 1, 20,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1, 10, 0, 0, 1, 30,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  2, 0, 0, 1, 30,  1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  1, 0, 0, 1, 31,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 1, 0, 3, 31,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 3, 31,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 3, 31,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 3, 31,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,  5, 0,  0, 0, 0, 1,  0,  5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  9, 0, 0, 1,  9,  5, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  0, 0,  0, 1, 0, 0,  0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rs, tbl[i].sv, tbl[i].sf, tbl[i].sp,
                 tbl[i].cv, tbl[i].cval, tbl[i].cf, tbl[i].cn);
            check($sformatf("table[%0d]", i), 32'(dutVec()),
                  32'({tbl[i].est, tbl[i].eim, tbl[i].evtp, tbl[i].ed, tbl[i].er, tbl[i].ee}));
        end

        // Timeout: coin at cycle e (k=1) -> REFUND observed at e+10.
        step(1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 1; k <= c_TIMEOUT; k++) begin
            if (k == 1) step(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0);
            else        idle();
            check($sformatf("timeout1 k=%0d", k), 32'(mainState),
                  (k < c_TIMEOUT) ? 32'd1 : 32'd2);
        end
        for (int k = 0; k <= c_HOLD; k++) idle();
        check("timeout1 idle", 32'(mainState), 32'd0);

        // Second coin at e+5 pushes REFUND out to e+15.
        step(1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            if (k == 1 || k == 6) step(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0);
            else                  idle();
            check($sformatf("timeout2 k=%0d", k), 32'(mainState),
                  (k < 15) ? 32'd1 : 32'd2);
        end
        check("timeout2 money", 32'(inputMoney), 32'd2);
        for (int k = 0; k <= c_HOLD; k++) idle();

        // Random traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 31)),
                 $urandom_range(0, 4) == 0,
                 5'($urandom_range(1, 12)),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 31) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
